ad7768_spi_seq: RTL and testbench
=================================

// Module: ad7768_spi_seq
// PURPOSE
// - Parametrised SPI register sequencer for the AD7768 control port. Replaces the fixed two-frame config block.
// - On one start pulse it issues 1..NUM_XFER frames, back to back, with a CS gap between frames.
// - For every frame it captures the low DATA_BITS of SDO and flags them valid.
// - Sits between the config/key logic (25 MHz domain) and the ADC pins.
// PARAMETERS
// NUM_XFER    2   max frames per sequence (1..16)
// FRAME_BITS  16  bits per frame, MSB first: {RW, ADDR[6:0], DATA[7:0]} for 16
// DATA_BITS   8   SDO bits captured per frame (LSBs of frame), <= FRAME_BITS
// DIV_HALF    2   clk cycles per SCK half-period (>=1); SCK = clk/(2*DIV_HALF)
// CS_GAP      18  clk cycles cs_n held high after each frame (>=1)
// PORTS
// clk           in   1                     system clock (25 MHz)
// rst_n         in   1                     async active-low reset
// start         in   1                     1-cycle request, honoured only when busy=0
// num_xfer      in   $clog2(NUM_XFER+1)    frames to run, sampled with start
// cmd_flat      in   NUM_XFER*FRAME_BITS   frame k at [k*FRAME_BITS +: FRAME_BITS], sampled with start
// sdo           in   1                     ADC serial data out
// busy          out  1                     high from accepted start until done
// done          out  1                     1-cycle pulse at end of sequence
// rd_data_flat  out  NUM_XFER*DATA_BITS    captured SDO data, frame k at [k*DATA_BITS +: DATA_BITS]
// rd_valid      out  NUM_XFER              bit k set when frame k captured; cleared on accepted start
// sck           out  1                     SPI clock, CPOL=0
// cs_n          out  1                     chip select, active low
// sdi           out  1                     serial data to ADC (registered)
// BEHAVIOUR
// - Reset: busy=0, done=0, rd_data_flat=0, rd_valid=0, sck=0, cs_n=1, sdi=0, state=IDLE.
// - FSM IDLE->SHIFT->GAP->(SHIFT | FINISH)->IDLE.
// - IDLE: start=1 and num_xfer!=0 -> latch cmd_flat, latch min(num_xfer,NUM_XFER), clear rd_valid, busy=1.
//   cs_n falls and sdi=frame0 MSB at the next edge; go to SHIFT.
// - start with num_xfer=0: busy stays 0, done pulses the next cycle, no SPI activity, rd_valid not cleared.
// - SHIFT: each bit lasts 2*DIV_HALF clks. sck is low for the first DIV_HALF clks and high for the next DIV_HALF.
//   sdo is sampled in the clk where sck rises. sdi advances to the next bit in the clk where sck falls.
//   Frame length = FRAME_BITS*2*DIV_HALF clks of cs_n low.
//   After the last bit: sck=0, cs_n=1, rd_data[k] = last DATA_BITS sampled, rd_valid[k]=1, go to GAP.
// - GAP: cs_n high for exactly CS_GAP clks. Then, if more frames remain, load the next frame, cs_n=0, go to SHIFT.
//   Otherwise go to FINISH.
// - FINISH: done=1 for one clk, busy=0, return to IDLE. Every frame, including the last, has its CS gap before done.
// - start while busy=1: ignored, no effect on the running sequence.
// - cmd_flat/num_xfer changing mid-sequence: no effect (latched copies are used).
// - rst_n asserted mid-frame: all outputs return to reset values asynchronously. cs_n goes high immediately.
//   The partial frame is discarded.
// - Counters: div counter wraps at 2*DIV_HALF-1, bit counter at FRAME_BITS-1, frame index at latched count-1.
//   No counter free-runs in IDLE.
// CONFIGURATION
// - AD7768_SPI_SDO_FALL_EN defined: sdo is sampled in the clk where sck falls (end of bit), for slow SDO paths.
//   The last bit is sampled at the frame's final falling edge, before cs_n rises.
// - AD7768_SPI_SDO_FALL_EN undefined: sdo is sampled on the sck rising edge as above.
//   Frame timing, cs_n and sdi are identical in both builds.
// TESTING
// 1. Reset then idle 50 clks: cs_n=1, sck=0, sdi=0, busy=0, done=0, rd_valid=0.
// 2. Two frames: num_xfer=2, cmd0=16'h0A55, cmd1=16'h8A00, SDO model returns 8'h3C then 8'hC3.
//    Expect sdi bits match MSB first; 16 sck pulses per frame; each cs_n low window = 64 clks.
//    Expect CS gaps = 18 clks; rd_data = {8'hC3,8'h3C}; rd_valid=2'b11; one done pulse.
// 3. num_xfer=0 -> done pulse 1 clk after start; cs_n never falls; busy stays 0.
// 4. start pulsed again mid-frame 0 of a 2-frame run -> sequence unchanged, exactly 2 frames, one done pulse.
// 5. rst_n low at bit 7 of frame 1 -> cs_n=1, sck=0 immediately, rd_valid=0.
//    A new start after release runs a clean sequence.
// 6. num_xfer=3 with NUM_XFER=2 -> clamped to 2 frames. Repeat test 2 with AD7768_SPI_SDO_FALL_EN:
//    an SDO model changing only on sck rise yields identical rd_data.

Source files
------------

// File: rtl/ad7768_spi_seq_if.sv
// Control bus between the config/key logic and the AD7768 SPI sequencer.
// master: requester (config logic); slave: the sequencer.
interface ad7768_spi_seq_if #(
  parameter int unsigned NUM_XFER   = 2,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_BITS  = 8
);
  localparam int unsigned CNT_W = $clog2(NUM_XFER + 1);

  logic                             start;
  logic [CNT_W-1:0]                 num_xfer;
  logic [NUM_XFER*FRAME_BITS-1:0]   cmd_flat;
  logic                             busy;
  logic                             done;
  logic [NUM_XFER*DATA_BITS-1:0]    rd_data_flat;
  logic [NUM_XFER-1:0]              rd_valid;

  modport master (
    output start, num_xfer, cmd_flat,
    input  busy, done, rd_data_flat, rd_valid
  );

  modport slave (
    input  start, num_xfer, cmd_flat,
    output busy, done, rd_data_flat, rd_valid
  );
endinterface

// File: rtl/ad7768_spi_seq.sv
// AD7768 control-port SPI sequencer: one start issues 1..NUM_XFER frames,
// MSB first, CPOL=0, with a cs_n gap after every frame, and captures the low
// DATA_BITS of SDO per frame.
// Build option: define AD7768_SPI_SDO_FALL_EN to sample sdo on the sck falling
// edge (end of bit) instead of the rising edge. Frame timing is unchanged.
module ad7768_spi_seq #(
  parameter int unsigned NUM_XFER   = 2,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DIV_HALF   = 2,
  parameter int unsigned CS_GAP     = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ad7768_spi_seq_if.slave       bus,
  input  logic                  sdo,
  output logic                  sck,
  output logic                  cs_n,
  output logic                  sdi
);

  localparam int unsigned CntW = $clog2(NUM_XFER + 1);
  localparam int unsigned IdxW = (NUM_XFER > 1) ? $clog2(NUM_XFER) : 1;
  localparam int unsigned DivW = $clog2(2 * DIV_HALF);
  localparam int unsigned BitW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [DivW-1:0] DivRise = DivW'(DIV_HALF - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(2 * DIV_HALF - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(FRAME_BITS - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap, StFinish} state_e;

  state_e                          state_q;
  logic [NUM_XFER*FRAME_BITS-1:0]  cmd_q;
  logic [CntW-1:0]                 cnt_q;
  logic [IdxW-1:0]                 idx_q;
  logic [DivW-1:0]                 div_q;
  logic [BitW-1:0]                 bit_q;
  logic [GapW-1:0]                 gap_q;
  logic [FRAME_BITS-1:0]           sh_q;
  logic [DATA_BITS-1:0]            cap_q;
  logic                            busy_q;
  logic                            done_q;
  logic [NUM_XFER*DATA_BITS-1:0]   rd_data_q;
  logic [NUM_XFER-1:0]             rd_valid_q;
  logic                            sck_q;
  logic                            cs_n_q;
  logic                            sdi_q;

  logic [DATA_BITS:0]              cap_ext;
  logic [DATA_BITS-1:0]            cap_nxt;
  logic [IdxW-1:0]                 idx_nxt;
  logic [FRAME_BITS-1:0]           frame_first;
  logic [FRAME_BITS-1:0]           frame_nxt;
  logic                            last_frame;

  // Capture shift, next-frame select and end-of-sequence decode
  always_comb begin
    cap_ext     = {cap_q, sdo};
    cap_nxt     = cap_ext[DATA_BITS-1:0];
    idx_nxt     = idx_q + IdxW'(1);
    frame_first = bus.cmd_flat[FRAME_BITS-1:0];
    frame_nxt   = cmd_q[32'(idx_nxt)*FRAME_BITS +: FRAME_BITS];
    last_frame  = ((32'(idx_q) + 32'd1) == 32'(cnt_q));
  end

  // Sequencer FSM with registered SPI pins and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      sh_q       <= '0;
      cap_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      sdi_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.num_xfer != '0) begin
              cmd_q      <= bus.cmd_flat;
              // Requests beyond the table size are clamped
              if (32'(bus.num_xfer) > NUM_XFER) cnt_q <= CntW'(NUM_XFER);
              else                              cnt_q <= bus.num_xfer;
              idx_q      <= '0;
              div_q      <= '0;
              bit_q      <= '0;
              cap_q      <= '0;
              rd_valid_q <= '0;
              busy_q     <= 1'b1;
              cs_n_q     <= 1'b0;
              sdi_q      <= frame_first[FRAME_BITS-1];
              sh_q       <= frame_first << 1;
              state_q    <= StShift;
            end else begin
              // Empty request: acknowledge without touching the bus
              done_q <= 1'b1;
            end
          end
        end

        StShift: begin
          if (div_q == DivRise) begin
            sck_q <= 1'b1;
`ifndef AD7768_SPI_SDO_FALL_EN
            cap_q <= cap_nxt;
`endif
          end
          if (div_q == DivLast) begin
            div_q <= '0;
            sck_q <= 1'b0;
`ifdef AD7768_SPI_SDO_FALL_EN
            cap_q <= cap_nxt;
`endif
            if (bit_q == BitLast) begin
              bit_q      <= '0;
              gap_q      <= '0;
              cs_n_q     <= 1'b1;
              sdi_q      <= 1'b0;
`ifdef AD7768_SPI_SDO_FALL_EN
              rd_data_q[32'(idx_q)*DATA_BITS +: DATA_BITS] <= cap_nxt;
`else
              rd_data_q[32'(idx_q)*DATA_BITS +: DATA_BITS] <= cap_q;
`endif
              rd_valid_q[idx_q] <= 1'b1;
              state_q    <= StGap;
            end else begin
              bit_q <= bit_q + BitW'(1);
              sdi_q <= sh_q[FRAME_BITS-1];
              sh_q  <= sh_q << 1;
            end
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end

        StGap: begin
          if (gap_q == GapLast) begin
            gap_q <= '0;
            if (last_frame) begin
              state_q <= StFinish;
            end else begin
              idx_q   <= idx_nxt;
              div_q   <= '0;
              cap_q   <= '0;
              cs_n_q  <= 1'b0;
              sdi_q   <= frame_nxt[FRAME_BITS-1];
              sh_q    <= frame_nxt << 1;
              state_q <= StShift;
            end
          end else begin
            gap_q <= gap_q + GapW'(1);
          end
        end

        StFinish: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.rd_data_flat = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign sck              = sck_q;
  assign cs_n             = cs_n_q;
  assign sdi              = sdi_q;

endmodule

// File: tb/tb_ad7768_spi_seq.sv
// Directed bench for ad7768_spi_seq with a behavioural AD7768 SDO model and a
// pin monitor measuring cs_n windows, gaps, sck pulses and sdi frames.
module tb_ad7768_spi_seq;

  localparam int unsigned NX = 2;
  localparam int unsigned FB = 16;
  localparam int unsigned DB = 8;
  localparam int unsigned DH = 2;
  localparam int unsigned GP = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sdo = 1'b0;
  logic sck, cs_n, sdi;

  always #5 clk = ~clk;

  ad7768_spi_seq_if #(.NUM_XFER(NX), .FRAME_BITS(FB), .DATA_BITS(DB)) bus ();

  ad7768_spi_seq #(
    .NUM_XFER(NX), .FRAME_BITS(FB), .DATA_BITS(DB), .DIV_HALF(DH), .CS_GAP(GP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .sdo  (sdo),
    .sck  (sck),
    .cs_n (cs_n),
    .sdi  (sdi)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC SDO model: 16-bit response word per frame, MSB first
  logic [15:0] resp [0:1];
  int mdl_frame = 0;
  int mdl_bit = 0;
  logic m_prev_cs = 1'b1;
  logic m_prev_sck = 1'b0;

  always @(posedge clk) begin
    #1;
    if (m_prev_cs && !cs_n) begin
      mdl_bit = 0;
`ifndef AD7768_SPI_SDO_FALL_EN
      sdo = (mdl_frame < 2) ? resp[mdl_frame][15] : 1'b0;
`endif
    end
`ifdef AD7768_SPI_SDO_FALL_EN
    // Slow-path model: new bit appears on sck rise
    if (!cs_n && sck && !m_prev_sck) begin
      sdo = (mdl_frame < 2 && mdl_bit < 16) ? resp[mdl_frame][15-mdl_bit] : 1'b0;
      mdl_bit++;
    end
`else
    // Normal model: next bit appears on sck fall
    if (!cs_n && !sck && m_prev_sck) begin
      mdl_bit++;
      sdo = (mdl_frame < 2 && mdl_bit < 16) ? resp[mdl_frame][15-mdl_bit] : 1'b0;
    end
`endif
    if (!m_prev_cs && cs_n) mdl_frame++;
    m_prev_cs  = cs_n;
    m_prev_sck = sck;
  end

  // Pin monitor
  int nfr, cur_low, cur_rises, cur_gap, gap_len, last_gap, done_cnt, done_wide;
  int cs_falls, sck_bad, busy_seen;
  int low_len [0:3];
  int rises [0:3];
  logic [15:0] sdi_word [0:3];
  logic [15:0] cur_sdi;
  logic in_gap, p_cs, p_sck, p_done;

  task automatic clear_mon();
    nfr = 0; cur_low = 0; cur_rises = 0; cur_gap = 0; gap_len = 0; last_gap = 0;
    done_cnt = 0; done_wide = 0; cs_falls = 0; sck_bad = 0; busy_seen = 0;
    cur_sdi = '0; in_gap = 1'b0; p_cs = 1'b1; p_sck = 1'b0; p_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      low_len[i] = 0; rises[i] = 0; sdi_word[i] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (!cs_n && p_cs) begin
      cs_falls++;
      if (in_gap) gap_len = cur_gap;
      in_gap = 1'b0; cur_low = 0; cur_rises = 0; cur_sdi = '0;
    end
    if (!cs_n) begin
      cur_low++;
      if (sck && !p_sck) begin
        cur_rises++;
        cur_sdi = {cur_sdi[14:0], sdi};
      end
    end
    if (cs_n && !p_cs) begin
      if (nfr < 4) begin
        low_len[nfr] = cur_low; rises[nfr] = cur_rises; sdi_word[nfr] = cur_sdi;
      end
      nfr++;
      in_gap = 1'b1; cur_gap = 0;
    end
    if (cs_n && in_gap) cur_gap++;
    if (cs_n && sck) sck_bad++;
    if (bus.busy) busy_seen++;
    if (bus.done) begin
      done_cnt++;
      if (in_gap) begin last_gap = cur_gap; in_gap = 1'b0; end
    end
    if (bus.done && p_done) done_wide++;
    p_cs = cs_n; p_sck = sck; p_done = bus.done;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(logic [1:0] n, logic [31:0] cmd);
    bus.num_xfer = n;
    bus.cmd_flat = cmd;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(string tag, int max);
    int n = 0;
    while (!bus.done && n < max) begin
      tick(1);
      n++;
    end
    check(tag, bus.done, 1'b1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.num_xfer = '0;
    bus.cmd_flat = '0;
    resp[0] = 16'h0000;
    resp[1] = 16'h0000;
    clear_mon();
    #17;
    rst_n = 1'b1;

    // 1: idle after reset
    tick(50);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_sdi", sdi, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_valid", bus.rd_valid, 2'b00);
    check("rst_data", bus.rd_data_flat, 16'h0000);
    check("rst_cs_falls", cs_falls, 0);

    // 2: two-frame sequence
    resp[0] = 16'hA53C; resp[1] = 16'h5AC3; mdl_frame = 0; clear_mon();
    pulse_start(2'd2, {16'h8A00, 16'h0A55});
    check("t2_busy", bus.busy, 1'b1);
    check("t2_valid_clr", bus.rd_valid, 2'b00);
    wait_done("t2_done_timeout", 1000);
    check("t2_busy_end", bus.busy, 1'b0);
    tick(5);
    check("t2_frames", nfr, 2);
    check("t2_low0", low_len[0], 64);
    check("t2_low1", low_len[1], 64);
    check("t2_sck0", rises[0], 16);
    check("t2_sck1", rises[1], 16);
    check("t2_sdi0", sdi_word[0], 16'h0A55);
    check("t2_sdi1", sdi_word[1], 16'h8A00);
    check("t2_gap", gap_len, GP);
    check("t2_last_gap", (last_gap >= int'(GP)), 1'b1);
    check("t2_data", bus.rd_data_flat, 16'hC33C);
    check("t2_valid", bus.rd_valid, 2'b11);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_done_wide", done_wide, 0);
    check("t2_sck_idle", sck_bad, 0);

    // 3: empty request
    clear_mon();
    pulse_start(2'd0, 32'h1234_5678);
    check("t3_done", bus.done, 1'b1);
    check("t3_busy", bus.busy, 1'b0);
    tick(1);
    check("t3_done_off", bus.done, 1'b0);
    tick(20);
    check("t3_cs_falls", cs_falls, 0);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_busy_seen", busy_seen, 0);
    check("t3_valid_kept", bus.rd_valid, 2'b11);

    // 4: start during a running sequence is ignored
    resp[0] = 16'h1196; resp[1] = 16'h2269; mdl_frame = 0; clear_mon();
    pulse_start(2'd2, {16'hF00F, 16'h1234});
    tick(20);
    pulse_start(2'd1, 32'hFFFF_FFFF);
    wait_done("t4_done_timeout", 1000);
    tick(5);
    check("t4_frames", nfr, 2);
    check("t4_sdi0", sdi_word[0], 16'h1234);
    check("t4_sdi1", sdi_word[1], 16'hF00F);
    check("t4_data", bus.rd_data_flat, 16'h6996);
    check("t4_done_cnt", done_cnt, 1);

    // 5: async reset mid frame 1
    resp[0] = 16'h00AA; resp[1] = 16'h0055; mdl_frame = 0; clear_mon();
    pulse_start(2'd2, {16'h8A00, 16'h0A55});
    begin
      int n = 0;
      while (!(nfr == 1 && !cs_n && cur_rises == 8) && n < 1000) begin
        tick(1);
        n++;
      end
    end
    check("t5_reached_bit7", (nfr == 1 && cur_rises == 8), 1'b1);
    check("t5_sck_high", sck, 1'b1);
    check("t5_valid_pre", bus.rd_valid, 2'b01);
    rst_n = 1'b0;
    #1;
    check("t5_cs_n", cs_n, 1'b1);
    check("t5_sck", sck, 1'b0);
    check("t5_valid", bus.rd_valid, 2'b00);
    check("t5_data", bus.rd_data_flat, 16'h0000);
    check("t5_busy", bus.busy, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    resp[0] = 16'h003C; resp[1] = 16'h00C3; mdl_frame = 0; clear_mon();
    pulse_start(2'd2, {16'h8A00, 16'h0A55});
    wait_done("t5_done_timeout", 1000);
    tick(5);
    check("t5_frames", nfr, 2);
    check("t5_rerun_data", bus.rd_data_flat, 16'hC33C);
    check("t5_rerun_valid", bus.rd_valid, 2'b11);

    // 6: request above NUM_XFER is clamped
    resp[0] = 16'hFF3C; resp[1] = 16'h00C3; mdl_frame = 0; clear_mon();
    pulse_start(2'd3, {16'h8A00, 16'h0A55});
    wait_done("t6_done_timeout", 1000);
    tick(40);
    check("t6_frames", nfr, 2);
    check("t6_data", bus.rd_data_flat, 16'hC33C);
    check("t6_valid", bus.rd_valid, 2'b11);
    check("t6_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
